imm_gen_stage: RTL and testbench

IMM_GEN_STAGE -- requirements
Module: imm_gen_stage

---
 rtl/imm_pkg.sv | 24 ++
 rtl/imm_decode.sv | 45 ++++
 rtl/imm_gen_stage.sv | 100 ++++++++++
 tb/tb_imm_gen_stage.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared encodings for the immediate-generation stage: immsrc formats and
// the occupancy encoding of the output/skid register pair.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I     = 3'b000,
    IMM_S     = 3'b001,
    IMM_B     = 3'b010,
    IMM_J     = 3'b011,
    IMM_U     = 3'b100,
    IMM_SHAMT = 3'b101,
    IMM_ZIMM  = 3'b110,
    IMM_RSVD  = 3'b111
  } immsrc_t;

  // Bit 0 is "output register full", bit 1 is "skid register full", so the
  // handshake outputs come straight off state flops.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_ONE   = 2'b01,
    OCC_TWO   = 2'b11
  } occ_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: extracts and extends the immediate
// selected by immsrc from a 32-bit instruction word.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instr,
  input  immsrc_t         immsrc,
  output logic [XLEN-1:0] immext,
  output logic            illegal
);

  logic signed [11:0] imm_i;
  logic signed [11:0] imm_s;
  logic signed [12:0] imm_b;
  logic signed [20:0] imm_j;
  logic signed [31:0] imm_u;
  logic               unused_opcode;

  assign imm_i = instr[31:20];
  assign imm_s = {instr[31:25], instr[11:7]};
  assign imm_b = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign unused_opcode = ^instr[6:0];

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    immext  = '0;
    illegal = 1'b0;
    unique case (immsrc)
      IMM_I:     immext = XLEN'(imm_i);
      IMM_S:     immext = XLEN'(imm_s);
      IMM_B:     immext = XLEN'(imm_b);
      IMM_J:     immext = XLEN'(imm_j);
      IMM_U:     immext = XLEN'(imm_u);
      IMM_SHAMT: immext = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
      IMM_ZIMM:  immext = XLEN'(instr[19:15]);
      IMM_RSVD:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Immediate-generation pipeline stage: decodes on the input side, then holds
// results in an output register backed by one skid register.
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       immsrc,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  immext,
  output logic [TAG_W-1:0] out_tag,
  output logic             illegal
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } item_t;

  item_t in_item, or_q, sk_q;
  occ_e  state_q, state_d;
  logic  xfer_in, xfer_out;
  logic  load_or_in, load_or_sk, load_sk;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr   (instr),
    .immsrc  (immsrc_t'(immsrc)),
    .immext  (in_item.imm),
    .illegal (in_item.illegal)
  );
  assign in_item.tag = in_tag;

  assign in_ready  = ~state_q[1];
  assign out_valid = state_q[0];
  assign xfer_in   = in_valid & in_ready;
  assign xfer_out  = out_valid & out_ready;

  always_comb begin
    state_d    = state_q;
    load_or_in = 1'b0;
    load_or_sk = 1'b0;
    load_sk    = 1'b0;
    unique case (state_q)
      OCC_EMPTY: begin
        if (xfer_in) begin
          state_d    = OCC_ONE;
          load_or_in = 1'b1;
        end
      end
      OCC_ONE: begin
        if (xfer_in && xfer_out) begin
          load_or_in = 1'b1;
        end else if (xfer_in) begin
          state_d = OCC_TWO;
          load_sk = 1'b1;
        end else if (xfer_out) begin
          state_d = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        if (xfer_out) begin
          state_d    = OCC_ONE;
          load_or_sk = 1'b1;
        end
      end
      default: state_d = OCC_EMPTY;
    endcase
    if (flush) state_d = OCC_EMPTY;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state_q <= OCC_EMPTY;
    else       state_q <= state_d;
  end

  // NOTE: payload registers carry no reset; the valid bits in state_q alone
  // decide whether their contents are ever observed.
  always_ff @(posedge clk) begin
    if (load_or_in)      or_q <= in_item;
    else if (load_or_sk) or_q <= sk_q;
    if (load_sk)         sk_q <= in_item;
  end

  assign immext  = or_q.imm;
  assign out_tag = or_q.tag;
  assign illegal = or_q.illegal;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: XLEN=64 and XLEN=32 instances share stimulus and
// are compared every cycle against a queue-based reference model.
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        reset, in_valid, flush, out_ready;
  logic [31:0] instr;
  logic [2:0]  immsrc;
  logic [4:0]  in_tag;

  logic        in_ready_a, out_valid_a, illegal_a;
  logic [63:0] immext_a;
  logic [4:0]  out_tag_a;
  logic        in_ready_b, out_valid_b, illegal_b;
  logic [31:0] immext_b;
  logic [4:0]  out_tag_b;

  int checks   = 0;
  int failures = 0;
  bit checking = 0;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  src;
    logic [4:0]  tag;
  } item_t;
  item_t q[$];

  imm_gen_stage #(.XLEN(64), .TAG_W(5)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
    .instr(instr), .immsrc(immsrc), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid_a), .out_ready(out_ready), .immext(immext_a),
    .out_tag(out_tag_a), .illegal(illegal_a)
  );

  imm_gen_stage #(.XLEN(32), .TAG_W(5)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
    .instr(instr), .immsrc(immsrc), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid_b), .out_ready(out_ready), .immext(immext_b),
    .out_tag(out_tag_b), .illegal(illegal_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic longint sext(input longint v, input int bits);
    if (v >= (longint'(1) << (bits - 1))) return v - (longint'(1) << bits);
    return v;
  endfunction

  function automatic logic [63:0] model_imm(input logic [31:0] ins, input logic [2:0] src, input int xlen);
    longint r;
    case (src)
      3'd0: r = sext(longint'(ins[31:20]), 12);
      3'd1: r = sext(longint'(ins[31:25]) * 32 + longint'(ins[11:7]), 12);
      3'd2: r = sext(longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 +
                     longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2, 13);
      3'd3: r = sext(longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096 +
                     longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2, 21);
      3'd4: r = sext(longint'(ins[31:12]) * 4096, 32);
      3'd5: r = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
      3'd6: r = longint'(ins[19:15]);
      default: r = 0;
    endcase
    if (xlen == 32) r = r & 64'h0000_0000_FFFF_FFFF;
    return r;
  endfunction

  // Reference model: a FIFO of at most two items.
  always @(posedge clk) begin
    bit do_in, do_out;
    item_t it;
    if (reset || flush) begin
      q.delete();
    end else begin
      do_in  = in_valid && (q.size() < 2);
      do_out = (q.size() > 0) && out_ready;
      it.instr = instr;
      it.src   = immsrc;
      it.tag   = in_tag;
      if (do_out) void'(q.pop_front());
      if (do_in) q.push_back(it);
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("out_valid64", 64'(out_valid_a), 64'(q.size() > 0));
      check("in_ready64",  64'(in_ready_a),  64'(q.size() < 2));
      check("out_valid32", 64'(out_valid_b), 64'(q.size() > 0));
      check("in_ready32",  64'(in_ready_b),  64'(q.size() < 2));
      if (q.size() > 0) begin
        check("immext64",  immext_a, model_imm(q[0].instr, q[0].src, 64));
        check("immext32",  64'(immext_b), model_imm(q[0].instr, q[0].src, 32));
        check("out_tag64", 64'(out_tag_a), 64'(q[0].tag));
        check("out_tag32", 64'(out_tag_b), 64'(q[0].tag));
        check("illegal64", 64'(illegal_a), 64'(q[0].src == 3'b111));
        check("illegal32", 64'(illegal_b), 64'(q[0].src == 3'b111));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; flush = 0; reset = 0;
  endtask

  // Push one item into an empty stage with out_ready=1 and check it one cycle later.
  task automatic send_one(input logic [31:0] ins, input logic [2:0] src,
                          input logic [63:0] exp64, input logic [31:0] exp32, input logic exp_ill);
    out_ready = 1; in_valid = 1; instr = ins; immsrc = src; in_tag = 5'd7;
    step();
    in_valid = 0;
    @(negedge clk);
    check("lit_valid", 64'(out_valid_a), 64'd1);
    check("lit_imm64", immext_a, exp64);
    check("lit_imm32", 64'(immext_b), 64'(exp32));
    check("lit_illegal", 64'(illegal_a), 64'(exp_ill));
    step();
  endtask

  task automatic fill_two();
    out_ready = 0; in_valid = 1; immsrc = 3'b000;
    instr = $urandom; in_tag = 5'd20; step();
    instr = $urandom; in_tag = 5'd21; step();
    in_valid = 0;
  endtask

  initial begin
    reset = 1; in_valid = 0; flush = 0; out_ready = 0;
    instr = '0; immsrc = '0; in_tag = '0;

    check("pin_I",     model_imm(32'hFFF00093, 3'd0, 64), 64'hFFFF_FFFF_FFFF_FFFF);
    check("pin_S",     model_imm(32'hFE112E23, 3'd1, 64), 64'hFFFF_FFFF_FFFF_FFFC);
    check("pin_B",     model_imm(32'hFE000EE3, 3'd2, 64), 64'hFFFF_FFFF_FFFF_FFFC);
    check("pin_J",     model_imm(32'hFFDFF06F, 3'd3, 64), 64'hFFFF_FFFF_FFFF_FFFC);
    check("pin_U64",   model_imm(32'h80000037, 3'd4, 64), 64'hFFFF_FFFF_8000_0000);
    check("pin_U32",   model_imm(32'h80000037, 3'd4, 32), 64'h0000_0000_8000_0000);
    check("pin_SH64",  model_imm(32'h03F01013, 3'd5, 64), 64'h3F);
    check("pin_SH32",  model_imm(32'h03F01013, 3'd5, 32), 64'h1F);
    check("pin_ZIMM",  model_imm(32'h0007D073, 3'd6, 64), 64'hF);

    step(); step();
    reset = 0;
    checking = 1;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid_a), 64'd0);
    check("rst_in_ready",  64'(in_ready_a),  64'd1);

    send_one(32'hFFF00093, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    send_one(32'hFE000EE3, 3'd2, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
    send_one(32'h80000037, 3'd4, 64'hFFFF_FFFF_8000_0000, 32'h8000_0000, 1'b0);
    send_one(32'h03F01013, 3'd5, 64'h3F, 32'h1F, 1'b0);
    send_one(32'hDEADBEEF, 3'd7, 64'h0, 32'h0, 1'b1);

    // Back-to-back tags 1,2,3 against a stalled consumer.
    out_ready = 0; in_valid = 1; immsrc = 3'd0; instr = 32'h00100093;
    in_tag = 5'd1; step();
    in_tag = 5'd2; step();
    @(negedge clk);
    check("bp_in_ready_low", 64'(in_ready_a), 64'd0);
    check("bp_tag_head", 64'(out_tag_a), 64'd1);
    in_tag = 5'd3; step();
    @(negedge clk);
    check("bp_hold_tag", 64'(out_tag_a), 64'd1);
    step();
    out_ready = 1; step();
    @(negedge clk);
    check("bp_tag2", 64'(out_tag_a), 64'd2);
    check("bp_in_ready_high", 64'(in_ready_a), 64'd1);
    step();
    in_valid = 0;
    @(negedge clk);
    check("bp_tag3", 64'(out_tag_a), 64'd3);
    step();
    @(negedge clk);
    check("bp_drained", 64'(out_valid_a), 64'd0);

    // Flush from TWO, then a fresh item passes through normally.
    fill_two();
    flush = 1; step();
    flush = 0;
    @(negedge clk);
    check("flush_out_valid", 64'(out_valid_a), 64'd0);
    check("flush_in_ready",  64'(in_ready_a),  64'd1);
    out_ready = 1; in_valid = 1; in_tag = 5'd9; instr = 32'h00500093; step();
    in_valid = 0;
    @(negedge clk);
    check("flush_next_valid", 64'(out_valid_a), 64'd1);
    check("flush_next_tag",   64'(out_tag_a),   64'd9);
    step();

    // Reset from TWO: held items must never reappear.
    fill_two();
    reset = 1; step();
    reset = 0;
    @(negedge clk);
    check("rst2_out_valid", 64'(out_valid_a), 64'd0);
    check("rst2_in_ready",  64'(in_ready_a),  64'd1);
    out_ready = 1; step(); step();
    @(negedge clk);
    check("rst2_stays_empty", 64'(out_valid_a), 64'd0);

    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 99) < 3);
      reset     = ($urandom_range(0, 99) < 1);
      instr     = $urandom;
      immsrc    = 3'($urandom_range(0, 7));
      in_tag    = 5'($urandom);
      step();
    end

    idle_inputs();
    out_ready = 1;
    repeat (5) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
